timer_scheduler: RTL and testbench
==================================

Name: timer_scheduler

Overview:
- Multi-channel timer scheduler. Shares one free-running timebase among NUM_CH requesters (core, DMA, watchdog, perf sampling).
- Each channel is armed with a relative delay, in one-shot or periodic mode.
- Channel expiries are queued as pending events. A round-robin arbiter delivers them to the consumer (interrupt/trap logic) one at a time over a valid/ready handshake.

Parameters:
- NUM_CH, 4, number of timer channels; must be ≥ 2.
- W, 32, width of the timebase and of delays.
- IDW, $clog2(NUM_CH), width of the event channel id.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- req_valid  input  NUM_CH  per-channel arm request
- req_ready  output  NUM_CH  per-channel arm accept; equals ~armed
- req_delay  input  NUM_CH*W  per-channel delay in cycles; channel i uses slice [i*W +: W]
- req_periodic  input  NUM_CH  per-channel mode sampled at accept: 1 = periodic, 0 = one-shot
- cancel  input  NUM_CH  per-channel disarm
- armed  output  NUM_CH  channel currently counting
- evt_valid  output  1  an event is presented
- evt_ready  input  1  consumer accepts the event
- evt_id  output  IDW  channel number of the presented event
- evt_overrun  output  1  presented channel expired again while its previous event was still pending
- now  output  W  free-running timebase

Behaviour:
- Reset: now=0, armed=0, all deadlines=0, periodic flags=0, pending=0, overrun=0, evt_valid=0, evt_id=0, evt_overrun=0, RR pointer=0.
  - req_ready=all ones in the cycle after reset.
  - Reset mid-operation discards all armed channels and pending events.
- Timebase: now increments by 1 every cycle and wraps from 2^W-1 to 0.
- Accept: channel i accepts when req_valid[i] && req_ready[i] in cycle t.
  - Effective delay D = max(req_delay, 1).
  - Deadline = now(t) + D mod 2^W.
  - armed[i]=1 from cycle t+1; the periodic flag and D are latched.
- Expiry: channel i expires in cycle t+D, detected by armed[i] && now == deadline[i]. Equality compare, so wrap-around is handled.
  - Delay 2^W-1 is legal and fires after 2^W-1 cycles.
  - One-shot: armed[i] clears at the end of the expiry cycle; req_ready[i]=1 from the next cycle.
  - Periodic: armed stays 1; deadline += D, so expiries occur at t+D, t+2D, …
- Expiry marks the channel pending:
  - If pending[i] is already 1 and is not being delivered this cycle, set overrun[i] (sticky).
- Cancel: cancel[i] clears armed[i] at the next edge.
  - Cancel in the same cycle as an expiry wins: no pending is set.
  - Cancel does not clear an already-pending event or overrun.
  - cancel with req_valid on an unarmed channel: the arm is accepted and the cancel is ignored.
- Event arbiter:
  - evt_valid=1 whenever any pending bit is set, registered (one cycle after the pending bit sets).
  - evt_id = first pending channel at or after the RR pointer, modulo NUM_CH.
  - While evt_valid && !evt_ready, evt_id and evt_overrun are held stable. New pending bits never change the presented event.
  - On evt_valid && evt_ready: pending[evt_id] and overrun[evt_id] clear; the RR pointer becomes evt_id+1 mod NUM_CH.
  - The next event may be presented in the following cycle: one event per cycle maximum throughput.
  - Handshake in the same cycle as a new expiry of the same channel: pending stays 1, overrun stays 0.
- Latency: accept to expiry = D cycles. Expiry to evt_valid = 1 cycle when the arbiter is idle.

Test Plan:
- Reset, then arm ch0 with delay 10 one-shot at now=5, evt_ready=1 → expiry at now=15; evt_valid=1, evt_id=0 at now=16; armed[0]=0 and req_ready[0]=1 afterwards.
- Arm ch1 with delay 0 → treated as 1; expires the cycle after accept. Arm ch2 with delay 3 at now=2^W-2 → expires at now=1 (wrap).
- Arm ch0..ch3 all with delay 20 in the same cycle, evt_ready=1 → four events with ids 0,1,2,3 on consecutive cycles. Re-run with RR pointer=2 → ids 2,3,0,1.
- Arm ch3 periodic with delay 4, evt_ready=0 for 10 cycles → evt_valid held, evt_id=3, evt_overrun=1. Assert ready → pending and overrun clear; the next period produces a fresh event with evt_overrun=0.
- Assert cancel[1] in the exact expiry cycle of ch1 → no event; armed[1]=0. Cancel ch2 after its event is pending → event is still delivered.
- Assert rst while two channels are armed and one event is pending → all outputs return to reset values and no events appear afterwards.

Source files
------------

// File: rtl/timer_scheduler.sv
// Multi-channel timer scheduler: one free-running timebase shared by NUM_CH
// one-shot/periodic channels, with expiries delivered round-robin over valid/ready.
module timer_scheduler #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned W      = 32,
  parameter int unsigned IDW    = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   req_valid,
  output logic [NUM_CH-1:0]   req_ready,
  input  logic [NUM_CH*W-1:0] req_delay,
  input  logic [NUM_CH-1:0]   req_periodic,
  input  logic [NUM_CH-1:0]   cancel,
  output logic [NUM_CH-1:0]   armed,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [IDW-1:0]      evt_id,
  output logic                evt_overrun,
  output logic [W-1:0]        now
);

  logic [W-1:0]      deadline_q [NUM_CH];
  logic [W-1:0]      period_q   [NUM_CH];
  logic [NUM_CH-1:0] periodic_q;
  logic [NUM_CH-1:0] pending_q;
  logic [NUM_CH-1:0] overrun_q;
  logic [IDW-1:0]    rr_q;

  logic [W-1:0]      delay_eff   [NUM_CH];
  logic [W-1:0]      deadline_nx [NUM_CH];
  logic [W-1:0]      period_nx   [NUM_CH];
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] expire;
  logic [NUM_CH-1:0] deliver;
  logic [NUM_CH-1:0] armed_nx;
  logic [NUM_CH-1:0] periodic_nx;
  logic [NUM_CH-1:0] pending_nx;
  logic [NUM_CH-1:0] overrun_nx;
  logic [IDW-1:0]    rr_nx;
  logic              sel_found;
  logic [IDW-1:0]    sel_id;
  int unsigned       sel_idx;

  assign req_ready = ~armed;

  always_comb begin
    deliver = '0;
    rr_nx   = rr_q;
    if (evt_valid && evt_ready) begin
      deliver[evt_id] = 1'b1;
      rr_nx = (evt_id == IDW'(NUM_CH - 1)) ? '0 : evt_id + IDW'(1);
    end

    accept      = '0;
    expire      = '0;
    armed_nx    = armed;
    periodic_nx = periodic_q;
    pending_nx  = pending_q;
    overrun_nx  = overrun_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      deadline_nx[i] = deadline_q[i];
      period_nx[i]   = period_q[i];
      delay_eff[i]   = req_delay[i*W +: W];
      if (delay_eff[i] == '0)
        delay_eff[i] = W'(1);

      accept[i] = req_valid[i] & ~armed[i];
      // A cancel in the expiry cycle suppresses the expiry entirely.
      expire[i] = armed[i] & ~cancel[i] & (now == deadline_q[i]);

      if (accept[i]) begin
        armed_nx[i]    = 1'b1;
        deadline_nx[i] = now + delay_eff[i];
        period_nx[i]   = delay_eff[i];
        periodic_nx[i] = req_periodic[i];
      end else if (cancel[i]) begin
        armed_nx[i] = 1'b0;
      end else if (expire[i]) begin
        if (periodic_q[i])
          deadline_nx[i] = deadline_q[i] + period_q[i];
        else
          armed_nx[i] = 1'b0;
      end

      pending_nx[i] = expire[i] | (pending_q[i] & ~deliver[i]);
      overrun_nx[i] = ~deliver[i] & (overrun_q[i] | (expire[i] & pending_q[i]));
    end

    sel_found = 1'b0;
    sel_id    = '0;
    sel_idx   = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      sel_idx = 32'(rr_nx) + k;
      if (sel_idx >= NUM_CH)
        sel_idx = sel_idx - NUM_CH;
      if (!sel_found && pending_nx[sel_idx]) begin
        sel_found = 1'b1;
        sel_id    = IDW'(sel_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      now         <= '0;
      armed       <= '0;
      periodic_q  <= '0;
      pending_q   <= '0;
      overrun_q   <= '0;
      rr_q        <= '0;
      evt_valid   <= 1'b0;
      evt_id      <= '0;
      evt_overrun <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        deadline_q[i] <= '0;
        period_q[i]   <= '0;
      end
    end else begin
      now        <= now + W'(1);
      armed      <= armed_nx;
      periodic_q <= periodic_nx;
      pending_q  <= pending_nx;
      overrun_q  <= overrun_nx;
      rr_q       <= rr_nx;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        deadline_q[i] <= deadline_nx[i];
        period_q[i]   <= period_nx[i];
      end
      // While stalled the id is frozen; only the sticky overrun of that channel may rise.
      if (evt_valid && !evt_ready) begin
        evt_overrun <= overrun_nx[evt_id];
      end else begin
        evt_valid   <= sel_found;
        evt_id      <= sel_id;
        evt_overrun <= sel_found & overrun_nx[sel_id];
      end
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler (4 channels, 8-bit timebase so wrap is reachable).
module tb_timer_scheduler;

  localparam int unsigned NCH = 4;
  localparam int unsigned TW  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_ready;
  logic [NCH*TW-1:0] req_delay;
  logic [NCH-1:0]    req_periodic;
  logic [NCH-1:0]    cancel;
  logic [NCH-1:0]    armed;
  logic              evt_valid;
  logic              evt_ready;
  logic [1:0]        evt_id;
  logic              evt_overrun;
  logic [TW-1:0]     now;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  timer_scheduler #(.NUM_CH(NCH), .W(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_delay(req_delay),
    .req_periodic(req_periodic), .cancel(cancel), .armed(armed),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_overrun(evt_overrun), .now(now)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rv;
    logic [3:0]  per;
    logic [3:0]  cnl;
    logic        rdy;
    logic [7:0]  dly;
    int unsigned reps;
    logic [3:0]  exp_armed;
    logic        exp_ev;
    logic [1:0]  exp_id;
    logic        exp_ov;
  } vec_t;

  vec_t tbl [19];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (now=%0d)", name, act, exp, now);
    end
  endtask

  task automatic wait_now(input logic [7:0] target);
    int unsigned n = 0;
    while (now !== target && n < 600) begin
      tick();
      n++;
    end
    chk("wait_now", 32'(now), 32'(target));
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    req_valid    = '0;
    req_periodic = '0;
    req_delay    = '0;
    cancel       = '0;
    evt_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_delay(input int unsigned ch, input logic [7:0] d);
    req_delay[ch*TW +: TW] = d;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_now"}, 32'(now), 0);
    chk({tag, "_armed"}, 32'(armed), 0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'hF);
    chk({tag, "_evt_valid"}, 32'(evt_valid), 0);
    chk({tag, "_evt_id"}, 32'(evt_id), 0);
    chk({tag, "_evt_overrun"}, 32'(evt_overrun), 0);
  endtask

  initial begin
    logic [3:0]  exp_rdy;
    int unsigned seen;

    // Cycle-by-cycle table, starting at now=0 after a fresh reset.
    tbl[0]  = '{4'hF, 4'h0, 4'h0, 1'b1, 8'd20,  1, 4'h0, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{4'h0, 4'h0, 4'h0, 1'b1, 8'd20, 20, 4'hF, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{4'h0, 4'h0, 4'h0, 1'b1, 8'd20,  1, 4'h0, 1'b1, 2'd0, 1'b0};
    tbl[3]  = '{4'h0, 4'h0, 4'h0, 1'b1, 8'd20,  1, 4'h0, 1'b1, 2'd1, 1'b0};
    tbl[4]  = '{4'h0, 4'h0, 4'h0, 1'b1, 8'd20,  1, 4'h0, 1'b1, 2'd2, 1'b0};
    tbl[5]  = '{4'h0, 4'h0, 4'h0, 1'b1, 8'd20,  1, 4'h0, 1'b1, 2'd3, 1'b0};
    tbl[6]  = '{4'h2, 4'h0, 4'h0, 1'b1, 8'd1,   1, 4'h0, 1'b0, 2'd0, 1'b0};
    tbl[7]  = '{4'h0, 4'h0, 4'h0, 1'b1, 8'd1,   1, 4'h2, 1'b0, 2'd0, 1'b0};
    tbl[8]  = '{4'h0, 4'h0, 4'h0, 1'b1, 8'd1,   1, 4'h0, 1'b1, 2'd1, 1'b0};
    tbl[9]  = '{4'hF, 4'h0, 4'h0, 1'b1, 8'd20,  1, 4'h0, 1'b0, 2'd0, 1'b0};
    tbl[10] = '{4'h0, 4'h0, 4'h0, 1'b1, 8'd20, 20, 4'hF, 1'b0, 2'd0, 1'b0};
    tbl[11] = '{4'h0, 4'h0, 4'h0, 1'b1, 8'd20,  1, 4'h0, 1'b1, 2'd2, 1'b0};
    tbl[12] = '{4'h0, 4'h0, 4'h0, 1'b1, 8'd20,  1, 4'h0, 1'b1, 2'd3, 1'b0};
    tbl[13] = '{4'h0, 4'h0, 4'h0, 1'b1, 8'd20,  1, 4'h0, 1'b1, 2'd0, 1'b0};
    tbl[14] = '{4'h0, 4'h0, 4'h0, 1'b1, 8'd20,  1, 4'h0, 1'b1, 2'd1, 1'b0};
    tbl[15] = '{4'h2, 4'h0, 4'h0, 1'b1, 8'd0,   1, 4'h0, 1'b0, 2'd0, 1'b0};
    tbl[16] = '{4'h0, 4'h0, 4'h0, 1'b1, 8'd0,   1, 4'h2, 1'b0, 2'd0, 1'b0};
    tbl[17] = '{4'h0, 4'h0, 4'h0, 1'b1, 8'd0,   1, 4'h0, 1'b1, 2'd1, 1'b0};
    tbl[18] = '{4'h0, 4'h0, 4'h0, 1'b1, 8'd0,   1, 4'h0, 1'b0, 2'd0, 1'b0};

    // One-shot ch0, delay 10 armed at now=5.
    do_reset();
    chk_reset_state("rst");
    evt_ready = 1'b1;
    wait_now(8'd5);
    req_valid = 4'h1;
    set_delay(0, 8'd10);
    tick();
    req_valid = '0;
    chk("os_armed", 32'(armed), 32'h1);
    chk("os_req_ready", 32'(req_ready), 32'hE);
    wait_now(8'd15);
    chk("os_no_evt_at_expiry", 32'(evt_valid), 0);
    chk("os_armed_at_expiry", 32'(armed), 32'h1);
    tick();
    chk("os_evt_valid", 32'(evt_valid), 1);
    chk("os_evt_id", 32'(evt_id), 0);
    chk("os_evt_overrun", 32'(evt_overrun), 0);
    chk("os_disarmed", 32'(armed), 0);
    chk("os_ready_back", 32'(req_ready), 32'hF);
    tick();
    chk("os_evt_drained", 32'(evt_valid), 0);

    // Table: simultaneous arm, round-robin order, RR pointer at 2, delay 0.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      for (int unsigned r = 0; r < tbl[i].reps; r++) begin
        req_valid    = tbl[i].rv;
        req_periodic = tbl[i].per;
        cancel       = tbl[i].cnl;
        evt_ready    = tbl[i].rdy;
        req_delay    = {4{tbl[i].dly}};
        exp_rdy      = ~tbl[i].exp_armed;
        chk("tbl_armed", 32'(armed), 32'(tbl[i].exp_armed));
        chk("tbl_req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("tbl_evt_valid", 32'(evt_valid), 32'(tbl[i].exp_ev));
        if (tbl[i].exp_ev) begin
          chk("tbl_evt_id", 32'(evt_id), 32'(tbl[i].exp_id));
          chk("tbl_evt_overrun", 32'(evt_overrun), 32'(tbl[i].exp_ov));
        end
        tick();
      end
    end

    // Wrap-around: ch2 delay 3 at now=254, then ch0 with the maximum delay 255.
    do_reset();
    evt_ready = 1'b1;
    wait_now(8'd254);
    req_valid = 4'h4;
    set_delay(2, 8'd3);
    tick();
    req_valid = '0;
    chk("wrap_armed", 32'(armed), 32'h4);
    tick();
    chk("wrap_now_zero", 32'(now), 0);
    chk("wrap_armed_0", 32'(armed), 32'h4);
    chk("wrap_no_evt_0", 32'(evt_valid), 0);
    tick();
    chk("wrap_armed_1", 32'(armed), 32'h4);
    chk("wrap_no_evt_1", 32'(evt_valid), 0);
    tick();
    chk("wrap_evt_valid", 32'(evt_valid), 1);
    chk("wrap_evt_id", 32'(evt_id), 2);
    chk("wrap_disarmed", 32'(armed), 0);
    req_valid = 4'h1;
    set_delay(0, 8'd255);
    tick();
    req_valid = '0;
    chk("max_armed", 32'(armed), 32'h1);
    wait_now(8'd1);
    chk("max_armed_expiry", 32'(armed), 32'h1);
    chk("max_no_evt_yet", 32'(evt_valid), 0);
    tick();
    chk("max_evt_valid", 32'(evt_valid), 1);
    chk("max_evt_id", 32'(evt_id), 0);
    chk("max_disarmed", 32'(armed), 0);

    // Periodic ch3 delay 4 with a stalled consumer, then overlapping handshake/expiry.
    do_reset();
    req_valid    = 4'h8;
    req_periodic = 4'h8;
    set_delay(3, 8'd4);
    tick();
    req_valid    = '0;
    req_periodic = '0;
    chk("per_armed", 32'(armed), 32'h8);
    wait_now(8'd5);
    for (int c = 5; c < 20; c++) begin
      chk("per_hold_valid", 32'(evt_valid), 1);
      chk("per_hold_id", 32'(evt_id), 3);
      chk("per_hold_overrun", 32'(evt_overrun), 32'(c >= 9));
      tick();
    end
    evt_ready = 1'b1;
    chk("per_ov_before_ack", 32'(evt_overrun), 1);
    tick();
    chk("per_fresh_valid", 32'(evt_valid), 1);
    chk("per_fresh_id", 32'(evt_id), 3);
    chk("per_fresh_overrun", 32'(evt_overrun), 0);
    chk("per_still_armed", 32'(armed), 32'h8);
    tick();
    chk("per_drained", 32'(evt_valid), 0);
    wait_now(8'd25);
    chk("per_next_valid", 32'(evt_valid), 1);
    chk("per_next_overrun", 32'(evt_overrun), 0);
    cancel = 4'h8;
    tick();
    cancel = '0;
    chk("per_cancelled", 32'(armed), 0);
    chk("per_cancel_drained", 32'(evt_valid), 0);
    wait_now(8'd30);
    chk("per_no_more", 32'(evt_valid), 0);

    // Cancel in ch1's expiry cycle; cancel ch2 after its event is pending.
    do_reset();
    req_valid    = 4'h6;
    req_periodic = 4'h4;
    set_delay(1, 8'd5);
    set_delay(2, 8'd3);
    tick();
    req_valid    = '0;
    req_periodic = '0;
    chk("cx_armed", 32'(armed), 32'h6);
    wait_now(8'd4);
    chk("cx_ch2_pending", 32'(evt_valid), 1);
    chk("cx_ch2_id", 32'(evt_id), 2);
    cancel = 4'h4;
    tick();
    chk("cx_ch2_disarmed", 32'(armed), 32'h2);
    cancel = 4'h2;
    tick();
    cancel = '0;
    chk("cx_ch1_disarmed", 32'(armed), 0);
    chk("cx_evt_kept", 32'(evt_valid), 1);
    chk("cx_evt_kept_id", 32'(evt_id), 2);
    tick();
    evt_ready = 1'b1;
    chk("cx_deliver_id", 32'(evt_id), 2);
    tick();
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (evt_valid) seen++;
      tick();
    end
    chk("cx_no_ch1_event", 32'(seen), 0);

    // Reset mid-operation with two channels armed and one event pending.
    do_reset();
    req_valid = 4'h7;
    set_delay(0, 8'd3);
    set_delay(1, 8'd50);
    set_delay(2, 8'd60);
    tick();
    req_valid = '0;
    wait_now(8'd6);
    chk("mr_pending", 32'(evt_valid), 1);
    chk("mr_armed", 32'(armed), 32'h6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state("mr");
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      if (evt_valid) seen++;
      tick();
    end
    chk("mr_no_events", 32'(seen), 0);
    chk("mr_still_idle", 32'(armed), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
